// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and display-enable decode,
// line/frame markers, and an incremental linear address for one sprite window.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 125,
  parameter int WIN_W  = 35,
  parameter int WIN_H  = 35,
  parameter int ADDR_W = 11
) (
  input  logic              vga_clk,
  input  logic              reset,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              line_start,
  output logic              frame_start,
  output logic [15:0]       frame_count,
  output logic              in_window,
  output logic [ADDR_W-1:0] win_addr
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] WX0      = 10'(WIN_X0);
  localparam logic [9:0] WY0      = 10'(WIN_Y0);
  localparam logic [9:0] WW       = 10'(WIN_W);
  localparam logic [9:0] WH       = 10'(WIN_H);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [9:0]        h_q, h_d;
  logic [9:0]        v_q, v_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              blank_q, blank_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              in_window_q, in_window_d;
  logic [ADDR_W-1:0] win_addr_q, win_addr_d;
  logic [9:0]        win_x_off, win_y_off;

  // Next raster position; both counters wrap together at the frame corner.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      if (v_q == V_LAST) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  // Decode for the pixel presented next cycle, so outputs line up with DrawX/DrawY.
  always_comb begin
    // Offsets wrap below the window origin, so a single unsigned compare covers both edges.
    win_x_off     = h_d - WX0;
    win_y_off     = v_d - WY0;
    blank_d       = (h_d < H_VIS_C) && (v_d < V_VIS_C);
    hs_d          = !((h_d >= HS_START) && (h_d < HS_END));
    vs_d          = !((v_d >= VS_START) && (v_d < VS_END));
    line_start_d  = (h_d == 10'd0);
    frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
    in_window_d   = blank_d && (win_x_off < WW) && (win_y_off < WH);
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
    if (frame_start_d) begin
      win_addr_d = '0;
    end else if (in_window_q) begin
      win_addr_d = win_addr_q + ADDR_ONE;
    end else begin
      win_addr_d = win_addr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
      in_window_q   <= 1'b0;
      win_addr_q    <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      in_window_q   <= in_window_d;
      win_addr_q    <= win_addr_d;
    end
  end

  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign in_window   = in_window_q;
  assign win_addr    = win_addr_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (25 x 17, window 5 x 4 at (3,4))
// so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX, DrawY;
  logic        hs, vs, blank, line_start, frame_start, in_window;
  logic [15:0] frame_count;
  logic [10:0] win_addr;

  int n_checks = 0;
  int n_fail   = 0;

  int pos_err, hs_low, vs_low, blank_cnt, blank_late, blank_wide;
  int ls_cnt, fs_cnt, win_cnt, first_hs, first_vs, first_win;

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .WIN_X0(3), .WIN_Y0(4), .WIN_W(5), .WIN_H(4), .ADDR_W(11)
  ) dut (
    .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .hs(hs), .vs(vs), .blank(blank), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count),
    .in_window(in_window), .win_addr(win_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_xy(input logic [9:0] x, input logic [9:0] y);
    int n = 0;
    while (!(DrawX == x && DrawY == y) && n < 600) begin
      step();
      n++;
    end
    check_eq("goto_xy", 32'({DrawY, DrawX}), 32'({y, x}));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_x"},   32'(DrawX), 32'd0);
    check_eq({tag, "_y"},   32'(DrawY), 32'd0);
    check_eq({tag, "_hs"},  32'(hs), 32'd1);
    check_eq({tag, "_vs"},  32'(vs), 32'd1);
    check_eq({tag, "_blk"}, 32'(blank), 32'd0);
    check_eq({tag, "_ls"},  32'(line_start), 32'd0);
    check_eq({tag, "_fs"},  32'(frame_start), 32'd0);
    check_eq({tag, "_win"}, 32'(in_window), 32'd0);
    check_eq({tag, "_wa"},  32'(win_addr), 32'd0);
    check_eq({tag, "_fc"},  32'(frame_count), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    check_reset_state("rst0");

    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("rel_x",   32'(DrawX), 32'd1);
    check_eq("rel_y",   32'(DrawY), 32'd0);
    check_eq("rel_blk", 32'(blank), 32'd1);
    check_eq("rel_hs",  32'(hs), 32'd1);
    check_eq("rel_ls",  32'(line_start), 32'd0);

    // First pulsed frame start: frame_count already 1
    goto_xy(10'd0, 10'd0);
    check_eq("fs1_fs",  32'(frame_start), 32'd1);
    check_eq("fs1_ls",  32'(line_start), 32'd1);
    check_eq("fs1_blk", 32'(blank), 32'd1);
    check_eq("fs1_fc",  32'(frame_count), 32'd1);

    pos_err = 0; hs_low = 0; vs_low = 0; blank_cnt = 0; blank_late = 0; blank_wide = 0;
    ls_cnt = 0; fs_cnt = 0; win_cnt = 0; first_hs = -1; first_vs = -1; first_win = -1;
    for (int i = 0; i < 425; i++) begin
      if (DrawX != 10'(i % 25) || DrawY != 10'(i / 25)) pos_err++;
      if (!hs) hs_low++;
      if (!hs && DrawY == 10'd0 && first_hs < 0) first_hs = int'(DrawX);
      if (!vs) vs_low++;
      if (!vs && first_vs < 0) first_vs = int'(DrawY);
      if (blank) blank_cnt++;
      if (blank && DrawY >= 10'd12) blank_late++;
      if (blank && DrawX >= 10'd16) blank_wide++;
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      if (in_window) win_cnt++;
      if (in_window && first_win < 0) first_win = int'({DrawY, DrawX});
      if (DrawX == 10'd3 && DrawY == 10'd4) check_eq("wa_3_4", 32'(win_addr), 32'd0);
      if (DrawX == 10'd7 && DrawY == 10'd4) check_eq("wa_7_4", 32'(win_addr), 32'd4);
      if (DrawX == 10'd3 && DrawY == 10'd5) check_eq("wa_3_5", 32'(win_addr), 32'd5);
      if (DrawX == 10'd7 && DrawY == 10'd7) check_eq("wa_7_7", 32'(win_addr), 32'd19);
      if (DrawX == 10'd24 && DrawY == 10'd16) check_eq("wa_hold", 32'(win_addr), 32'd20);
      step();
    end
    check_eq("pos_track",  32'(pos_err), 32'd0);
    check_eq("hs_low",     32'(hs_low), 32'd68);
    check_eq("hs_first",   32'(first_hs), 32'd18);
    check_eq("vs_low",     32'(vs_low), 32'd50);
    check_eq("vs_first",   32'(first_vs), 32'd13);
    check_eq("blank_cnt",  32'(blank_cnt), 32'd192);
    check_eq("blank_late", 32'(blank_late), 32'd0);
    check_eq("blank_wide", 32'(blank_wide), 32'd0);
    check_eq("ls_cnt",     32'(ls_cnt), 32'd17);
    check_eq("fs_cnt",     32'(fs_cnt), 32'd1);
    check_eq("win_cnt",    32'(win_cnt), 32'd20);
    check_eq("win_first",  32'(first_win), 32'd4099);

    // Next frame: counter advanced, window address restarted
    check_eq("fs2_fs", 32'(frame_start), 32'd1);
    check_eq("fs2_fc", 32'(frame_count), 32'd2);
    check_eq("fs2_wa", 32'(win_addr), 32'd0);

    // Reset asserted mid-line while hsync is active
    goto_xy(10'd20, 10'd9);
    check_eq("pre_rst_hs", 32'(hs), 32'd0);
    reset = 1'b1;
    step();
    check_reset_state("rst1");
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("rel2_x",  32'(DrawX), 32'd1);
    check_eq("rel2_y",  32'(DrawY), 32'd0);
    check_eq("rel2_hs", 32'(hs), 32'd1);
    check_eq("rel2_vs", 32'(vs), 32'd1);
    goto_xy(10'd3, 10'd4);
    check_eq("rel2_win", 32'(in_window), 32'd1);
    check_eq("rel2_wa",  32'(win_addr), 32'd0);

    // Preload frame_count just below wrap
    step();
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    check_eq("fc_preload", 32'(frame_count), 32'hFFFF);
    goto_xy(10'd0, 10'd0);
    check_eq("wrap_fc",  32'(frame_count), 32'd0);
    check_eq("wrap_fs",  32'(frame_start), 32'd1);
    check_eq("wrap_blk", 32'(blank), 32'd1);
    check_eq("wrap_hs",  32'(hs), 32'd1);
    check_eq("wrap_vs",  32'(vs), 32'd1);
    check_eq("wrap_win", 32'(in_window), 32'd0);
    check_eq("wrap_wa",  32'(win_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives DrawX, DrawY and blank to every sprite/image renderer on the VGA path.
- Produces active-low hsync/vsync plus line and frame markers for the display.
- Also generates a linear sprite-ROM address for one rectangular window, so renderers do not need a multiplier in their address path.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
WIN_X0, 0, window left column
WIN_Y0, 125, window top row
WIN_W, 35, window width (pixels)
WIN_H, 35, window height (pixels)
ADDR_W, 11, width of win_addr

Ports:
vga_clk  input  1  pixel clock; sole clock
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current column, 0..H_TOT-1
DrawY  output  10  current row, 0..V_TOT-1
hs  output  1  horizontal sync, active low
vs  output  1  vertical sync, active low
blank  output  1  1 = visible pixel (display enable), 0 = blanking
line_start  output  1  1-cycle pulse at DrawX==0
frame_start  output  1  1-cycle pulse at DrawX==0 && DrawY==0
frame_count  output  16  completed-frame counter
in_window  output  1  1 = current pixel inside sprite window and visible
win_addr  output  ADDR_W  linear sprite index of current pixel

Behaviour:
- Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
- The horizontal counter increments every vga_clk. At H_TOT-1 it wraps to 0 and the vertical counter advances. The vertical counter wraps to 0 after V_TOT-1.
- DrawX/DrawY are the counter registers themselves.
- All other outputs are registered from next-state counter values, so every output describes the same pixel in the same cycle as DrawX/DrawY. There is no relative skew.
- hs = 0 iff H_VIS+H_FP <= DrawX < H_VIS+H_FP+H_SYNC (hs low for DrawX 656..751 at defaults).
- vs = 0 iff V_VIS+V_FP <= DrawY < V_VIS+V_FP+V_SYNC (vs low for DrawY 490..491 at defaults).
- blank = (DrawX < H_VIS) && (DrawY < V_VIS).
- frame_count increments by 1 on the cycle frame_start asserts, excluding the first post-reset frame. It wraps modulo 2^16.
- in_window = blank && WIN_X0 <= DrawX < WIN_X0+WIN_W && WIN_Y0 <= DrawY < WIN_Y0+WIN_H.
- win_addr is an incremental counter, never a multiply.
  - It equals the number of in-window pixels already presented in the current frame.
  - It resets to 0 at frame start and increments after each in_window pixel.
  - It holds its value outside the window.
  - While in_window=1 it therefore equals (DrawY-WIN_Y0)*WIN_W + (DrawX-WIN_X0). Final value 1224 at defaults.
- Parameter constraints: WIN_X0+WIN_W <= H_VIS, WIN_Y0+WIN_H <= V_VIS, WIN_W*WIN_H <= 2^ADDR_W. Violating them is unsupported.
- Reset (any time, including mid-line or in sync):
  - DrawX=DrawY=0, hs=vs=1, blank=0, line_start=frame_start=0, in_window=0, win_addr=0, frame_count=0.
  - Pixel (0,0) of the first frame after reset is presented with blank=0 and no pulses.
  - From the first edge after release, output is pixel (1,0) with normal decode.
  - Timing resumes from (0,0) with no partial-frame artefacts.
- Simultaneous wrap at (H_TOT-1, V_TOT-1) goes to (0,0) in one edge. frame_start, line_start, blank=1 and the frame_count increment coincide.

Test Plan:
- Reset released, run 420000 cycles -> frame_start pulses exactly every 420000 cycles; frame_count = 1 at the second frame_start.
- Monitor line 0 -> hs low for exactly 96 cycles starting DrawX=656; blank high for DrawX 0..639 only; line_start every 800 cycles.
- Monitor full frame -> vs low for DrawY 490..491 (1600 cycles); blank=0 for all DrawY >= 480.
- Window defaults -> in_window first at (0,125) with win_addr=0; (34,125) gives 34; (0,126) gives 35; (34,159) gives 1224; next frame restarts at 0.
- Assert reset at DrawX=700, DrawY=300 for 3 cycles -> outputs at reset values; after release the first sample is DrawX=1, DrawY=0, hs=vs=1; win_addr=0 at (0,125).
- Drive frame_count to 0xFFFF via a forced start value, run one frame -> wraps to 0x0000; no other output perturbed.
